// File: rtl/hit_judge_pkg.sv
// Shared types and constants for the two-player hit judge: score width,
// saturation limit and the per-player judgement state encoding.
package hit_judge_pkg;

  localparam int SCORE_W = 5;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } player_state_e;

  // Scores stick at SCORE_MAX so the winner comparator never sees a wrap.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/hit_judge_player.sv
// One player's judgement: button edge register, IDLE/ARMED/DONE state,
// saturating score and registered hit/miss pulses.
module player_judge
  import hit_judge_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               strobe_i,
  input  logic               close_i,
  input  logic               freeze_i,
  input  logic               clear_i,
  input  logic               btn_i,
  output logic [SCORE_W-1:0] score_o,
  output logic               hit_o,
  output logic               miss_o
);

  player_state_e      state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               btn_q, btn_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;
  logic               rise;

  assign rise = btn_i & ~btn_q;

  always_comb begin
    btn_d   = btn_i;
    state_d = state_q;
    score_d = score_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    if (clear_i) begin
      state_d = IDLE;
      score_d = '0;
    end else if (!freeze_i) begin
      if (strobe_i) begin
        // A press coinciding with a new note counts for the new note and
        // swallows any miss still owed for the old one.
        if (rise) begin
          state_d = DONE;
          hit_d   = 1'b1;
          score_d = sat_inc(score_q);
        end else begin
          state_d = ARMED;
          miss_d  = (state_q == ARMED);
        end
      end else begin
        unique case (state_q)
          ARMED: begin
            if (rise) begin
              state_d = DONE;
              hit_d   = 1'b1;
              score_d = sat_inc(score_q);
            end else if (close_i) begin
              state_d = IDLE;
              miss_d  = 1'b1;
            end
          end
          DONE: begin
            miss_d = rise;
            if (close_i) state_d = IDLE;
          end
          default: begin
            state_d = IDLE;
            miss_d  = rise;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      score_q <= '0;
      btn_q   <= 1'b0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      btn_q   <= btn_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign score_o = score_q;
  assign hit_o   = hit_q;
  assign miss_o  = miss_q;

endmodule

// File: rtl/hit_judge.sv
// Two-player hit judge: a shared judgement window opened by note_strobe,
// with one player_judge per player producing scores and hit/miss pulses.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int WIN_CYCLES = 25_000_000,
  parameter int CNT_W      = 25
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               freeze,
  input  logic               note_strobe,
  input  logic               btn1,
  input  logic               btn2,
  output logic [SCORE_W-1:0] result1,
  output logic [SCORE_W-1:0] result2,
  output logic               hit1,
  output logic               hit2,
  output logic               miss1,
  output logic               miss2,
  output logic               window_open
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIN_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             open_q, open_d;
  logic             close;

  // The last open cycle is the one where the counter has reached zero.
  assign close = open_q & (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    open_d = open_q;
    if (clear) begin
      cnt_d  = '0;
      open_d = 1'b0;
    end else if (!freeze) begin
      if (note_strobe) begin
        cnt_d  = CNT_LOAD;
        open_d = 1'b1;
      end else if (close) begin
        open_d = 1'b0;
      end else if (open_q) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      open_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      open_q <= open_d;
    end
  end

  assign window_open = open_q;

  player_judge u_p1 (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .strobe_i (note_strobe),
    .close_i  (close),
    .freeze_i (freeze),
    .clear_i  (clear),
    .btn_i    (btn1),
    .score_o  (result1),
    .hit_o    (hit1),
    .miss_o   (miss1)
  );

  player_judge u_p2 (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .strobe_i (note_strobe),
    .close_i  (close),
    .freeze_i (freeze),
    .clear_i  (clear),
    .btn_i    (btn2),
    .score_o  (result2),
    .hit_o    (hit2),
    .miss_o   (miss2)
  );

endmodule
